// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT datapath control blocks.
// FFT_STAT_W is also the statistic width used by scale_factor_tracker.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        REPORT  = 2'd2
    } fft_mon_state_e;

    localparam int FFT_DATA_WIDTH = 16;
    localparam int FFT_GUARD_BITS = 2;
    localparam int FFT_STAT_W     = 8;

endpackage

// File: rtl/fft_leading_one_detector.sv
// Combinational leading-one detector.
// Returns the index of the highest set bit and a zero flag.
module fft_leading_one_detector #(
    parameter int W = 17
) (
    input  logic [W-1:0]         i_val,
    output logic [$clog2(W)-1:0] o_idx,
    output logic                 o_zero
);

    localparam int PW = $clog2(W);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_val[i]) begin
                o_idx = i[PW-1:0];
            end
        end
    end

    assign o_zero = ~|i_val;

endmodule

// File: rtl/fft_overflow_monitor.sv
// Per-stage overflow monitor and block-floating-point rescale controller.
// Tracks the peak butterfly magnitude and reports at stage end.
module fft_overflow_monitor
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int GUARD_BITS = FFT_GUARD_BITS
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         fft_start_i,
    input  logic                         scale_en_i,
    input  logic                         stage_start_i,
    input  logic [7:0]                   stage_idx_i,
    input  logic                         bf_valid_i,
    input  logic                         bf_last_i,
    input  logic signed [DATA_WIDTH-1:0] bf_real_i,
    input  logic signed [DATA_WIDTH-1:0] bf_imag_i,
    output logic                         stage_complete_o,
    output logic                         scale_factor_increment_o,
    output logic                         overflow_detected_o,
    output logic [FFT_STAT_W-1:0]        overflow_magnitude_o,
    output logic [7:0]                   overflow_stage_o,
    output logic                         rescale_shift_o,
    output logic                         busy_o,
    output logic                         protocol_error_o
);

    localparam int MW       = DATA_WIDTH + 1;
    localparam int PW       = $clog2(MW);
    localparam int BASE     = DATA_WIDTH - 1 - GUARD_BITS;
    localparam int STAT_MAX = (1 << FFT_STAT_W) - 1;
    localparam logic [MW-1:0] ONE    = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] THRESH = ONE << BASE;

    fft_mon_state_e r_state;
    logic [MW-1:0]  r_max;
    logic [7:0]     r_idx;

    logic [MW-1:0]         w_ext_re;
    logic [MW-1:0]         w_ext_im;
    logic [MW-1:0]         w_abs_re;
    logic [MW-1:0]         w_abs_im;
    logic [MW-1:0]         w_a;
    logic                  w_accept;
    logic                  w_end;
    logic [MW-1:0]         w_m_base;
    logic [MW-1:0]         w_m_next;
    logic [7:0]            w_idx;
    logic [PW-1:0]         w_msb;
    logic                  w_zero;
    logic                  w_ovf;
    int                    w_mag_int;
    logic [FFT_STAT_W-1:0] w_mag;
    logic                  w_perr_set;

    // One extra bit keeps |most negative code| exact instead of wrapping.
    assign w_ext_re = {bf_real_i[DATA_WIDTH-1], bf_real_i};
    assign w_ext_im = {bf_imag_i[DATA_WIDTH-1], bf_imag_i};
    assign w_abs_re = bf_real_i[DATA_WIDTH-1] ? (~w_ext_re + ONE) : w_ext_re;
    assign w_abs_im = bf_imag_i[DATA_WIDTH-1] ? (~w_ext_im + ONE) : w_ext_im;
    assign w_a      = (w_abs_re > w_abs_im) ? w_abs_re : w_abs_im;

    // A sample arriving with stage_start_i belongs to the new stage.
    assign w_accept = bf_valid_i & (stage_start_i | (r_state == MONITOR));
    assign w_end    = w_accept & bf_last_i;
    assign w_m_base = stage_start_i ? '0 : r_max;
    assign w_m_next = (w_accept && (w_a > w_m_base)) ? w_a : w_m_base;
    assign w_idx    = stage_start_i ? stage_idx_i : r_idx;

    fft_leading_one_detector #(
        .W (MW)
    ) u_lod (
        .i_val  (w_m_next),
        .o_idx  (w_msb),
        .o_zero (w_zero)
    );

    assign w_ovf     = !w_zero && (w_m_next >= THRESH);
    assign w_mag_int = int'(w_msb) - BASE + 1;

    always_comb begin
        w_mag = '0;
        if (w_ovf) begin
            if (w_mag_int > STAT_MAX) begin
                w_mag = {FFT_STAT_W{1'b1}};
            end else begin
                w_mag = w_mag_int[FFT_STAT_W-1:0];
            end
        end
    end

    assign w_perr_set = (bf_valid_i & ~w_accept)
                      | (stage_start_i & (r_state == MONITOR));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state                  <= IDLE;
            r_max                    <= '0;
            r_idx                    <= '0;
            stage_complete_o         <= 1'b0;
            scale_factor_increment_o <= 1'b0;
            overflow_detected_o      <= 1'b0;
            overflow_magnitude_o     <= '0;
            overflow_stage_o         <= '0;
            rescale_shift_o          <= 1'b0;
            busy_o                   <= 1'b0;
            protocol_error_o         <= 1'b0;
        end else if (fft_start_i) begin
            r_state                  <= IDLE;
            r_max                    <= '0;
            r_idx                    <= '0;
            stage_complete_o         <= 1'b0;
            scale_factor_increment_o <= 1'b0;
            overflow_detected_o      <= 1'b0;
            overflow_magnitude_o     <= '0;
            overflow_stage_o         <= '0;
            rescale_shift_o          <= 1'b0;
            busy_o                   <= 1'b0;
            protocol_error_o         <= 1'b0;
        end else begin
            r_max                    <= w_m_next;
            stage_complete_o         <= w_end;
            overflow_detected_o      <= w_end & w_ovf;
            scale_factor_increment_o <= w_end & w_ovf & scale_en_i;
            busy_o <= w_end | stage_start_i | (r_state == MONITOR);
            if (stage_start_i) begin
                r_idx <= stage_idx_i;
            end
            if (w_perr_set) begin
                protocol_error_o <= 1'b1;
            end
            if (w_end) begin
                rescale_shift_o      <= w_ovf & scale_en_i;
                overflow_magnitude_o <= w_mag;
                if (w_ovf) begin
                    overflow_stage_o <= w_idx;
                end
            end
            if (w_end) begin
                r_state <= REPORT;
            end else if (stage_start_i) begin
                r_state <= MONITOR;
            end else if (r_state == MONITOR) begin
                r_state <= MONITOR;
            end else begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_fft_overflow_monitor.sv
// Randomized self-checking bench for fft_overflow_monitor.
// Expected report values come from a per-stage sample-list model.
module tb_fft_overflow_monitor;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        fft_start_i;
    logic        scale_en_i;
    logic        stage_start_i;
    logic [7:0]  stage_idx_i;
    logic        bf_valid_i;
    logic        bf_last_i;
    logic signed [15:0] bf_real_i;
    logic signed [15:0] bf_imag_i;
    logic        stage_complete_o;
    logic        scale_factor_increment_o;
    logic        overflow_detected_o;
    logic [7:0]  overflow_magnitude_o;
    logic [7:0]  overflow_stage_o;
    logic        rescale_shift_o;
    logic        busy_o;
    logic        protocol_error_o;

    int n_chk  = 0;
    int n_fail = 0;

    bit pend = 0;
    int p_det = 0, p_inc = 0;
    int exp_mag = 0, exp_stage = 0, exp_shift = 0;
    int exp_err = 0, exp_busy = 0;

    fft_overflow_monitor #(
        .DATA_WIDTH (16),
        .GUARD_BITS (2)
    ) dut (
        .clk_i                    (clk),
        .reset_n_i                (reset_n_i),
        .fft_start_i              (fft_start_i),
        .scale_en_i               (scale_en_i),
        .stage_start_i            (stage_start_i),
        .stage_idx_i              (stage_idx_i),
        .bf_valid_i               (bf_valid_i),
        .bf_last_i                (bf_last_i),
        .bf_real_i                (bf_real_i),
        .bf_imag_i                (bf_imag_i),
        .stage_complete_o         (stage_complete_o),
        .scale_factor_increment_o (scale_factor_increment_o),
        .overflow_detected_o      (overflow_detected_o),
        .overflow_magnitude_o     (overflow_magnitude_o),
        .overflow_stage_o         (overflow_stage_o),
        .rescale_shift_o          (rescale_shift_o),
        .busy_o                   (busy_o),
        .protocol_error_o         (protocol_error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int hb(input int v);
        int h = 0;
        while ((v >> (h + 1)) != 0) h++;
        return h;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Check every output against the model, then return inputs to rest.
    task automatic tick();
        @(posedge clk);
        #1;
        check("complete", 32'(stage_complete_o), 32'(pend));
        check("detected", 32'(overflow_detected_o), pend ? p_det : 0);
        check("increment", 32'(scale_factor_increment_o), pend ? p_inc : 0);
        check("shift", 32'(rescale_shift_o), exp_shift);
        check("magnitude", 32'(overflow_magnitude_o), exp_mag);
        check("ostage", 32'(overflow_stage_o), exp_stage);
        check("perr", 32'(protocol_error_o), exp_err);
        check("busy", 32'(busy_o), exp_busy);
        pend          = 0;
        fft_start_i   = 0;
        stage_start_i = 0;
        bf_valid_i    = 0;
        bf_last_i     = 0;
        bf_real_i     = '0;
        bf_imag_i     = '0;
    endtask

    task automatic idle_tick();
        tick();
        exp_busy = 0;
    endtask

    task automatic fft_clear();
        tick();
        fft_start_i = 1;
        exp_shift = 0;
        exp_mag   = 0;
        exp_stage = 0;
        exp_err   = 0;
        exp_busy  = 0;
    endtask

    task automatic do_stage(input int idx, input int n, input int pv,
                            input int kpos, input bit sen);
        int re[$];
        int im[$];
        int k, lim, mx, mag;
        bit ovf;
        k   = (kpos < 0) ? int'($urandom_range(0, n - 1)) : kpos;
        lim = iabs(pv);
        if (lim > 32767) lim = 32767;
        mx = 0;
        for (int i = 0; i < n; i++) begin
            int r, m;
            r = int'($urandom_range(0, 2 * lim)) - lim;
            m = int'($urandom_range(0, 2 * lim)) - lim;
            if (i == k) begin
                if ($urandom_range(0, 1) == 1) r = pv;
                else m = pv;
            end
            re.push_back(r);
            im.push_back(m);
            if (iabs(r) > mx) mx = iabs(r);
            if (iabs(m) > mx) mx = iabs(m);
        end
        ovf = (mx >= 8192);
        mag = ovf ? (hb(mx) - 13 + 1) : 0;
        for (int i = 0; i < n; i++) begin
            tick();
            stage_start_i = (i == 0);
            stage_idx_i   = 8'(idx);
            bf_valid_i    = 1;
            bf_last_i     = (i == n - 1);
            bf_real_i     = 16'(re[i]);
            bf_imag_i     = 16'(im[i]);
            scale_en_i    = sen;
            exp_busy      = 1;
        end
        pend      = 1;
        p_det     = ovf;
        p_inc     = ovf & sen;
        exp_shift = ovf & sen;
        exp_mag   = mag;
        if (ovf) exp_stage = idx;
    endtask

    initial begin
        reset_n_i     = 0;
        fft_start_i   = 0;
        scale_en_i    = 0;
        stage_start_i = 0;
        stage_idx_i   = '0;
        bf_valid_i    = 0;
        bf_last_i     = 0;
        bf_real_i     = '0;
        bf_imag_i     = '0;
        tick();
        reset_n_i = 1;
        tick();

        do_stage(0, 8, 4000, -1, 1);
        idle_tick();
        tick();

        do_stage(3, 6, 9000, -1, 1);
        idle_tick();
        tick();
        tick();

        // fft_start_i together with the last sample wipes the report
        tick();
        stage_start_i = 1;
        stage_idx_i   = 8'd7;
        bf_valid_i    = 1;
        bf_real_i     = 16'sd20000;
        scale_en_i    = 1;
        exp_busy      = 1;
        tick();
        bf_valid_i  = 1;
        bf_last_i   = 1;
        bf_real_i   = 16'sd9000;
        fft_start_i = 1;
        exp_shift = 0;
        exp_mag   = 0;
        exp_stage = 0;
        exp_busy  = 0;
        tick();
        tick();

        do_stage(1, 4, -32768, -1, 1);
        do_stage(2, 5, 20000, 0, 1);
        idle_tick();
        tick();

        do_stage(4, 3, 16000, -1, 0);
        idle_tick();

        // sample in IDLE is ignored and flags an error
        tick();
        bf_valid_i = 1;
        bf_real_i  = 16'sd20000;
        exp_err    = 1;
        tick();
        do_stage(5, 3, 1000, -1, 1);
        idle_tick();
        fft_clear();
        tick();

        // restart mid-stage drops the aborted samples
        tick();
        stage_start_i = 1;
        stage_idx_i   = 8'd5;
        bf_valid_i    = 1;
        bf_real_i     = 16'sd30000;
        scale_en_i    = 1;
        exp_busy      = 1;
        tick();
        bf_valid_i = 1;
        bf_real_i  = -16'sd30000;
        tick();
        stage_start_i = 1;
        stage_idx_i   = 8'd6;
        bf_valid_i    = 1;
        bf_real_i     = 16'sd100;
        exp_err       = 1;
        tick();
        bf_valid_i = 1;
        bf_last_i  = 1;
        bf_real_i  = 16'sd50;
        pend      = 1;
        p_det     = 0;
        p_inc     = 0;
        exp_shift = 0;
        exp_mag   = 0;
        idle_tick();
        fft_clear();
        tick();

        // asynchronous reset in the middle of a stage
        do_stage(9, 4, 30000, -1, 1);
        idle_tick();
        tick();
        stage_start_i = 1;
        stage_idx_i   = 8'd10;
        bf_valid_i    = 1;
        bf_real_i     = 16'sd30000;
        exp_busy      = 1;
        tick();
        bf_valid_i = 1;
        bf_real_i  = 16'sd5;
        #2;
        reset_n_i = 0;
        #1;
        check("rst_shift", 32'(rescale_shift_o), 0);
        check("rst_mag", 32'(overflow_magnitude_o), 0);
        check("rst_ostage", 32'(overflow_stage_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        exp_shift = 0;
        exp_mag   = 0;
        exp_stage = 0;
        exp_err   = 0;
        exp_busy  = 0;
        tick();
        reset_n_i = 1;
        tick();

        for (int s = 0; s < 25; s++) begin
            int v;
            int pv;
            v  = int'($urandom_range(0, 32768));
            pv = ($urandom_range(0, 1) == 1 || v == 32768) ? -v : v;
            do_stage(int'($urandom_range(0, 255)),
                     int'($urandom_range(1, 10)), pv, -1,
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                idle_tick();
            end
        end
        idle_tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
